w0rm_elastic_buffer: RTL and testbench

//  Parametrised valid/ready elastic buffer: the successor to the single-register synchroniser stage.

---
 rtl/w0rm_pkg.sv | 18 +
 rtl/w0rm_elastic_mem.sv | 27 ++
 rtl/w0rm_elastic_buffer.sv | 109 ++++++++++
 tb/tb_w0rm_elastic_buffer.sv | 249 ++++++++++++++++++++++++
 4 files changed

// File: rtl/w0rm_pkg.sv
// Shared W0RM stream constants and helpers, reused by every stream block.
package w0rm_pkg;

    localparam int W0RM_DATA_WIDTH = 32;

    // Constant-foldable ceil(log2(value)); returns 0 for value <= 1.
    function automatic int clog2(input int value);
        int result;
        result = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < value) begin
                result = i + 1;
            end
        end
        return result;
    endfunction

endpackage

// File: rtl/w0rm_elastic_mem.sv
// Storage array for the elastic buffer: synchronous write, asynchronous read, no reset.
module w0rm_elastic_mem
    import w0rm_pkg::*;
#(
    parameter int DATA_WIDTH = W0RM_DATA_WIDTH,
    parameter int DEPTH      = 2,
    parameter int AW         = clog2(DEPTH)
) (
    input  logic                  clk,
    input  logic                  wr_en,
    input  logic [AW-1:0]         wr_addr,
    input  logic [DATA_WIDTH-1:0] wr_data,
    input  logic [AW-1:0]         rd_addr,
    output logic [DATA_WIDTH-1:0] rd_data
);

    logic [DATA_WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

    assign rd_data = mem[rd_addr];

endmodule

// File: rtl/w0rm_elastic_buffer.sv
// Valid/ready elastic buffer holding up to DEPTH words in strict FIFO order,
// with an optional registered input_ready to cut the ready path between stages.
module w0rm_elastic_buffer
    import w0rm_pkg::*;
#(
    parameter int   DATA_WIDTH   = W0RM_DATA_WIDTH,
    parameter int   DEPTH        = 2,
    parameter bit   REG_READY    = 1'b1,
    parameter bit   ZERO_INVALID = 1'b1,
    localparam int  CW           = clog2(DEPTH + 1)
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  flush,
    input  logic                  input_valid,
    output logic                  input_ready,
    input  logic [DATA_WIDTH-1:0] input_data,
    input  logic                  output_ready,
    output logic                  output_valid,
    output logic [DATA_WIDTH-1:0] output_data,
    output logic [CW-1:0]         level
);

    localparam int PW = clog2(DEPTH);

    logic [PW-1:0]         wr_ptr;
    logic [PW-1:0]         rd_ptr;
    logic [CW-1:0]         level_q;
    logic [CW-1:0]         level_next;
    logic                  push;
    logic                  pop;
    logic [DATA_WIDTH-1:0] head_data;

    // DEPTH need not be a power of two, so wrap explicitly.
    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    assign push         = input_valid & input_ready;
    assign pop          = output_valid & output_ready;
    assign output_valid = (level_q != '0);
    assign level        = level_q;

    always_comb begin
        level_next = level_q;
        if (flush) begin
            level_next = '0;
        end else begin
            level_next = level_q + CW'(push) - CW'(pop);
        end
    end

    always_ff @(posedge clk) begin
        if (reset || flush) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            level_q <= '0;
        end else begin
            if (push) begin
                wr_ptr <= ptr_inc(wr_ptr);
            end
            if (pop) begin
                rd_ptr <= ptr_inc(rd_ptr);
            end
            level_q <= level_next;
        end
    end

    generate
        if (REG_READY) begin : g_reg_ready
            logic ready_q;

            always_ff @(posedge clk) begin
                if (reset) begin
                    ready_q <= 1'b0;
                end else begin
                    ready_q <= (level_next != CW'(DEPTH));
                end
            end

            assign input_ready = ready_q;
        end else begin : g_comb_ready
            // When full, a same-cycle pop frees the head slot the push overwrites.
            assign input_ready = ~reset & ((level_q != CW'(DEPTH)) | output_ready);
        end
    endgenerate

    w0rm_elastic_mem #(
        .DATA_WIDTH (DATA_WIDTH),
        .DEPTH      (DEPTH),
        .AW         (PW)
    ) u_mem (
        .clk     (clk),
        .wr_en   (push & ~flush),
        .wr_addr (wr_ptr),
        .wr_data (input_data),
        .rd_addr (rd_ptr),
        .rd_data (head_data)
    );

    generate
        if (ZERO_INVALID) begin : g_zero_invalid
            assign output_data = output_valid ? head_data : '0;
        end else begin : g_raw_data
            assign output_data = head_data;
        end
    endgenerate

endmodule

// File: tb/tb_w0rm_elastic_buffer.sv
// Scoreboard bench: instance A (DEPTH=4, registered ready), instance B (DEPTH=2, comb ready).
module tb_w0rm_elastic_buffer;

    localparam int DW = 32;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    logic          a_flush = 1'b0, a_iv = 1'b0, a_or = 1'b0;
    logic [DW-1:0] a_id = '0;
    logic          a_ir, a_ov;
    logic [DW-1:0] a_od;
    logic [2:0]    a_lvl;

    logic          b_flush = 1'b0, b_iv = 1'b0, b_or = 1'b0;
    logic [DW-1:0] b_id = '0;
    logic          b_ir, b_ov;
    logic [DW-1:0] b_od;
    logic [1:0]    b_lvl;

    int total = 0;
    int bad   = 0;
    int b_pops = 0;

    w0rm_elastic_buffer #(.DATA_WIDTH(DW), .DEPTH(4), .REG_READY(1'b1), .ZERO_INVALID(1'b1)) u_a (
        .clk(clk), .reset(reset), .flush(a_flush),
        .input_valid(a_iv), .input_ready(a_ir), .input_data(a_id),
        .output_ready(a_or), .output_valid(a_ov), .output_data(a_od), .level(a_lvl)
    );

    w0rm_elastic_buffer #(.DATA_WIDTH(DW), .DEPTH(2), .REG_READY(1'b0), .ZERO_INVALID(1'b1)) u_b (
        .clk(clk), .reset(reset), .flush(b_flush),
        .input_valid(b_iv), .input_ready(b_ir), .input_data(b_id),
        .output_ready(b_or), .output_valid(b_ov), .output_data(b_od), .level(b_lvl)
    );

    task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Reference model A: FIFO queue, ready registered from the post-edge occupancy.
    logic [DW-1:0] qa[$];
    logic rdy_a = 1'b0;
    initial begin : mon_a
        logic          s_rst, s_fl, s_push, s_pop;
        logic [DW-1:0] s_d;
        s_rst = 1'b1; s_fl = 1'b0; s_push = 1'b0; s_pop = 1'b0; s_d = '0;
        forever begin
            @(posedge clk);
            if (s_rst || s_fl) begin
                qa.delete();
            end else begin
                if (s_pop) void'(qa.pop_front());
                if (s_push) qa.push_back(s_d);
            end
            rdy_a = !s_rst && (qa.size() != 4);
            @(negedge clk);
            check("a_valid", 32'(a_ov), 32'(qa.size() != 0));
            check("a_level", 32'(a_lvl), 32'(qa.size()));
            check("a_data", a_od, (qa.size() != 0) ? qa[0] : '0);
            check("a_ready", 32'(a_ir), 32'(rdy_a));
            s_rst  = reset;
            s_fl   = a_flush;
            s_push = a_iv && rdy_a;
            s_pop  = (qa.size() != 0) && a_or;
            s_d    = a_id;
        end
    end

    // Reference model B: FIFO queue, ready = not full or consumer ready.
    logic [DW-1:0] qb[$];
    initial begin : mon_b
        logic          s_rst, s_fl, s_push, s_pop, exp_rdy;
        logic [DW-1:0] s_d;
        s_rst = 1'b1; s_fl = 1'b0; s_push = 1'b0; s_pop = 1'b0; s_d = '0;
        forever begin
            @(posedge clk);
            if (s_rst || s_fl) begin
                qb.delete();
            end else begin
                if (s_pop) begin
                    void'(qb.pop_front());
                    b_pops++;
                end
                if (s_push) qb.push_back(s_d);
            end
            @(negedge clk);
            exp_rdy = !reset && ((qb.size() != 2) || b_or);
            check("b_valid", 32'(b_ov), 32'(qb.size() != 0));
            check("b_level", 32'(b_lvl), 32'(qb.size()));
            check("b_data", b_od, (qb.size() != 0) ? qb[0] : '0);
            check("b_ready", 32'(b_ir), 32'(exp_rdy));
            s_rst  = reset;
            s_fl   = b_flush;
            s_push = b_iv && exp_rdy;
            s_pop  = (qb.size() != 0) && b_or;
            s_d    = b_id;
        end
    end

    initial begin : driver
        int pops_start;

        step();
        check("rst_a_ready", 32'(a_ir), 32'd0);
        check("rst_a_valid", 32'(a_ov), 32'd0);
        check("rst_a_data", a_od, 32'd0);
        step();
        step();
        reset = 1'b0;
        step();
        check("a_ready_rise", 32'(a_ir), 32'd1);

        // Fill A with output stalled.
        for (int i = 0; i < 4; i++) begin
            a_iv = 1'b1;
            a_id = 32'hA1 + DW'(i);
            step();
        end
        a_iv = 1'b0;
        check("a_full_level", 32'(a_lvl), 32'd4);
        check("a_full_ready", 32'(a_ir), 32'd0);
        check("a_full_head", a_od, 32'hA1);

        // Drain A.
        a_or = 1'b1;
        step();
        check("a_ready_after_pop", 32'(a_ir), 32'd1);
        check("a_second_head", a_od, 32'hA2);
        step();
        step();
        step();
        a_or = 1'b0;
        check("a_drained_level", 32'(a_lvl), 32'd0);
        check("a_drained_data", a_od, 32'd0);

        // B: continuous streaming, one word per cycle.
        pops_start = b_pops;
        b_iv = 1'b1;
        b_or = 1'b1;
        for (int i = 0; i < 100; i++) begin
            b_id = 32'h1000 + DW'(i);
            step();
            check("b_stream_level", 32'(b_lvl), 32'd1);
        end
        b_iv = 1'b0;
        step();
        check("b_stream_pops", 32'(b_pops - pops_start), 32'd100);
        check("b_stream_empty", 32'(b_lvl), 32'd0);

        // B: push while full accompanied by a pop.
        b_or = 1'b0;
        b_iv = 1'b1;
        b_id = 32'hB1;
        step();
        b_id = 32'hB2;
        step();
        check("b_full_level", 32'(b_lvl), 32'd2);
        check("b_full_ready", 32'(b_ir), 32'd0);
        b_id = 32'hB5;
        b_or = 1'b1;
        #1;
        check("b_full_pop_ready", 32'(b_ir), 32'd1);
        step();
        b_iv = 1'b0;
        check("b_pushpop_level", 32'(b_lvl), 32'd2);
        check("b_pushpop_head", b_od, 32'hB2);
        step();
        check("b_tail_word", b_od, 32'hB5);
        step();
        b_or = 1'b0;
        check("b_tail_empty", 32'(b_lvl), 32'd0);

        // A: flush with a concurrent push.
        a_iv = 1'b1;
        for (int i = 0; i < 3; i++) begin
            a_id = 32'hC1 + DW'(i);
            step();
        end
        check("a_preflush_level", 32'(a_lvl), 32'd3);
        a_flush = 1'b1;
        a_id = 32'hCC;
        step();
        a_flush = 1'b0;
        a_iv = 1'b0;
        check("a_flush_level", 32'(a_lvl), 32'd0);
        check("a_flush_valid", 32'(a_ov), 32'd0);
        step();
        check("a_flush_no_emit", 32'(a_ov), 32'd0);

        // Reset in the middle of traffic.
        a_iv = 1'b1;
        a_id = 32'hD1;
        step();
        a_id = 32'hD2;
        step();
        check("a_prereset_level", 32'(a_lvl), 32'd2);
        reset = 1'b1;
        for (int i = 0; i < 20; i++) begin
            a_iv = 1'($urandom_range(0, 1));
            a_or = 1'($urandom_range(0, 1));
            a_id = $urandom;
            b_iv = 1'($urandom_range(0, 1));
            b_or = 1'($urandom_range(0, 1));
            b_id = $urandom;
            step();
            check("rst_mid_a_ready", 32'(a_ir), 32'd0);
            check("rst_mid_a_valid", 32'(a_ov), 32'd0);
            check("rst_mid_b_valid", 32'(b_ov), 32'd0);
            #1;
            check("rst_mid_b_ready", 32'(b_ir), 32'd0);
        end
        reset = 1'b0;

        // Random traffic; the monitors compare against the queues.
        for (int i = 0; i < 300; i++) begin
            a_iv    = 1'($urandom_range(0, 1));
            a_or    = 1'($urandom_range(0, 2) != 0);
            a_id    = $urandom;
            a_flush = ($urandom_range(0, 31) == 0);
            b_iv    = 1'($urandom_range(0, 2) != 0);
            b_or    = 1'($urandom_range(0, 1));
            b_id    = $urandom;
            b_flush = ($urandom_range(0, 31) == 0);
            step();
        end
        a_iv = 1'b0; b_iv = 1'b0;
        a_flush = 1'b0; b_flush = 1'b0;
        a_or = 1'b1; b_or = 1'b1;
        repeat (6) step();
        check("final_a_level", 32'(a_lvl), 32'd0);
        check("final_b_level", 32'(b_lvl), 32'd0);

        @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
